sprite_renderer: RTL

SPRITE_RENDERER -- requirements
Module: sprite_renderer

---
 rtl/vga_pkg.sv | 36 +++
 rtl/sprite_hit_pipe.sv | 72 +++++++
 rtl/sprite_renderer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg
//   Shared 640x480 timing constants, wall FSM encoding and helper functions.
//   Revision: 1.0
// ============================================================================
package vga_pkg;

    localparam int c_h_active = 640;
    localparam int c_v_active = 480;
    localparam int c_h_total  = 800;
    localparam int c_v_total  = 525;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WALL  = 2'd1,
        ST_STUCK = 2'd2
    } wall_state_t;

    function automatic int clamp_int(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

    // Scan coordinates are unsigned; widening by one bit keeps the difference exact.
    function automatic logic [10:0] signed_offset(input logic [10:0] a, input logic [10:0] b);
        return a - b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_hit_pipe.sv
`default_nettype none
// ============================================================================
// sprite_hit_pipe
//   Two-stage in-box compare of the scan position against the sprite centre,
//   producing the pixel colour two cycles after the scan inputs.
//   Revision: 1.0
// ============================================================================
module sprite_hit_pipe
    import vga_pkg::*;
#(
    parameter int          HALF_SIZE  = 8,
    parameter logic [11:0] SPRITE_RGB = 12'hF00,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic [9:0]  pos_x,
    input  logic [8:0]  pos_y,
    output logic [11:0] rgb,
    output logic        sprite_on,
    output logic        video_on_d
);

    localparam logic signed [10:0] c_lo = 11'(-HALF_SIZE);
    localparam logic signed [10:0] c_hi = 11'(HALF_SIZE - 1);

    logic signed [10:0] r_dx;
    logic signed [10:0] r_dy;
    logic               r_vid1;
    logic               w_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dx   <= '0;
            r_dy   <= '0;
            r_vid1 <= 1'b0;
        end else begin
            r_dx   <= signed_offset({1'b0, hcount}, {1'b0, pos_x});
            r_dy   <= signed_offset({1'b0, vcount}, {2'b00, pos_y});
            r_vid1 <= video_on;
        end
    end

    always_comb begin
        w_hit = r_vid1
             && (r_dx >= c_lo) && (r_dx <= c_hi)
             && (r_dy >= c_lo) && (r_dy <= c_hi);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb        <= 12'h000;
            sprite_on  <= 1'b0;
            video_on_d <= 1'b0;
        end else begin
            sprite_on  <= w_hit;
            video_on_d <= r_vid1;
            if (w_hit) begin
                rgb <= SPRITE_RGB;
            end else if (r_vid1) begin
                rgb <= BG_RGB;
            end else begin
                rgb <= 12'h000;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
// sprite_renderer
//   Square sprite renderer with per-frame position latch, wall detection and
//   a wall-dwell FSM that flags a sprite stuck against the screen bounds.
//   Revision: 1.0
// ============================================================================
module sprite_renderer
    import vga_pkg::*;
#(
    parameter int          HALF_SIZE   = 8,
    parameter logic [11:0] SPRITE_RGB  = 12'hF00,
    parameter logic [11:0] BG_RGB      = 12'h000,
    parameter int          WALL_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x_sat,
    input  logic [8:0]  pixel_y_sat,
    input  logic        frame_start,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    output logic [11:0] rgb,
    output logic        video_on_d,
    output logic        sprite_on,
    output logic        at_wall,
    output logic        stuck
);

    localparam int c_x_lo_i = HALF_SIZE;
    localparam int c_x_hi_i = c_h_active - 1 - HALF_SIZE;
    localparam int c_y_lo_i = HALF_SIZE;
    localparam int c_y_hi_i = c_v_active - 1 - HALF_SIZE;

    localparam logic [9:0] c_x_lo  = 10'(c_x_lo_i);
    localparam logic [9:0] c_x_hi  = 10'(c_x_hi_i);
    localparam logic [8:0] c_y_lo  = 9'(c_y_lo_i);
    localparam logic [8:0] c_y_hi  = 9'(c_y_hi_i);
    localparam logic [9:0] c_x_rst = 10'(c_h_active / 2);
    localparam logic [8:0] c_y_rst = 9'(c_v_active / 2);

    localparam int                 c_cnt_w   = $clog2(WALL_FRAMES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WALL_FRAMES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [9:0]         r_pos_x;
    logic [8:0]         r_pos_y;
    logic               r_eval;
    logic               r_at_wall;
    logic               r_stuck;
    wall_state_t        r_state;
    logic [c_cnt_w-1:0] r_wall_cnt;

    logic [9:0]         w_x_clamped;
    logic [8:0]         w_y_clamped;
    logic               w_pos_at_wall;
    logic [c_cnt_w-1:0] w_cnt_inc;

    always_comb begin
        w_x_clamped = 10'(clamp_int(int'(pixel_x_sat), c_x_lo_i, c_x_hi_i));
        w_y_clamped = 9'(clamp_int(int'(pixel_y_sat), c_y_lo_i, c_y_hi_i));
    end

    // Loaded only at frame_start so the sprite never tears mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos_x <= c_x_rst;
            r_pos_y <= c_y_rst;
            r_eval  <= 1'b0;
        end else begin
            r_eval <= frame_start;
            if (frame_start) begin
                r_pos_x <= w_x_clamped;
                r_pos_y <= w_y_clamped;
            end
        end
    end

    // Built from the latched position, so a coincident new load is seen next cycle.
    always_comb begin
        w_pos_at_wall = (r_pos_x == c_x_lo) || (r_pos_x == c_x_hi)
                     || (r_pos_y == c_y_lo) || (r_pos_y == c_y_hi);
        w_cnt_inc     = r_wall_cnt + c_cnt_one;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_FREE;
            r_wall_cnt <= '0;
            r_at_wall  <= 1'b0;
            r_stuck    <= 1'b0;
        end else if (r_eval) begin
            r_at_wall <= w_pos_at_wall;
            case (r_state)
                ST_FREE: begin
                    if (w_pos_at_wall) begin
                        r_state    <= ST_WALL;
                        r_wall_cnt <= c_cnt_one;
                    end else begin
                        r_wall_cnt <= '0;
                    end
                    r_stuck <= 1'b0;
                end
                ST_WALL: begin
                    if (w_pos_at_wall) begin
                        if (r_wall_cnt < c_cnt_max) begin
                            r_wall_cnt <= w_cnt_inc;
                        end
                        if (w_cnt_inc >= c_cnt_max) begin
                            r_state <= ST_STUCK;
                            r_stuck <= 1'b1;
                        end
                    end else begin
                        r_state    <= ST_FREE;
                        r_wall_cnt <= '0;
                        r_stuck    <= 1'b0;
                    end
                end
                ST_STUCK: begin
                    if (!w_pos_at_wall) begin
                        r_state    <= ST_FREE;
                        r_wall_cnt <= '0;
                        r_stuck    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_FREE;
                    r_wall_cnt <= '0;
                    r_stuck    <= 1'b0;
                end
            endcase
        end
    end

    assign at_wall = r_at_wall;
    assign stuck   = r_stuck;

    sprite_hit_pipe #(
        .HALF_SIZE  (HALF_SIZE),
        .SPRITE_RGB (SPRITE_RGB),
        .BG_RGB     (BG_RGB)
    ) u_hit_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .video_on   (video_on),
        .pos_x      (r_pos_x),
        .pos_y      (r_pos_y),
        .rgb        (rgb),
        .sprite_on  (sprite_on),
        .video_on_d (video_on_d)
    );

endmodule
`default_nettype wire
